// File: rtl/dmem_wait_responder.sv
// Data-memory responder: word RAM plus tohost MMIO register behind a fixed-latency ready handshake.
// One access in flight; ready is sampled high at edge N+LATENCY for a request sampled at edge N, and writes commit on that edge.
module dmem_wait_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 1024,
  parameter int                    LATENCY     = 2,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter logic [DATA_WIDTH-1:0] DONE_MAGIC  = 32'hdeadbeef
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    write,
  input  logic                    read,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    err,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   tohost
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(DEPTH);
  localparam int WW = ADDR_WIDTH - 2;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WW-1:0]         waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         wstrb_q, wstrb_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] tohost_q, tohost_d;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  logic [WW-1:0]         sel_waddr;
  logic                  sel_wr, sel_rd;
  logic [IW-1:0]         ram_idx;
  logic                  is_tohost, in_range;
  logic [DATA_WIDTH-1:0] old_word, merged;
  logic                  go_resp, mem_we;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  // In IDLE the live bus is decoded so a LATENCY=1 response can be formed on the capture edge.
  always_comb begin
    sel_waddr = waddr_q;
    sel_wr    = wr_q;
    sel_rd    = rd_q;
    if (state_q == S_IDLE) begin
      sel_waddr = addr[ADDR_WIDTH-1:2];
      sel_wr    = write;
      sel_rd    = read;
    end
    ram_idx   = sel_waddr[IW-1:0];
    is_tohost = (sel_waddr == TOHOST_ADDR[ADDR_WIDTH-1:2]);
    in_range  = (sel_waddr[WW-1:IW] == '0);
    old_word  = is_tohost ? tohost_q : mem_array[ram_idx];
    merged    = old_word;
    for (int i = 0; i < NB; i++) begin
      if (wstrb_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    done_d   = done_q;
    tohost_d = tohost_q;
    go_resp  = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          waddr_d = addr[ADDR_WIDTH-1:2];
          wdata_d = wdata;
          wstrb_d = wstrb;
          wr_d    = write;
          rd_d    = read;
          cnt_d   = CW'(LATENCY - 1);
          if (LATENCY == 1) go_resp = 1'b1;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) go_resp = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (wr_q) begin
          if (is_tohost) begin
            tohost_d = merged;
            if (merged == DONE_MAGIC) done_d = 1'b1;
          end else if (in_range) begin
            mem_we = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Simultaneous read and write is handled as a write, so only a pure read returns data.
    if (go_resp) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      err_d   = (sel_rd && sel_wr) || (!is_tohost && !in_range);
      if (sel_rd && !sel_wr) begin
        if (is_tohost)     rdata_d = tohost_q;
        else if (in_range) rdata_d = mem_array[ram_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      tohost_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      tohost_q <= tohost_d;
    end
  end

  // RAM contents survive reset; they are preloaded externally.
  always_ff @(posedge clk) begin
    if (mem_we) mem_array[ram_idx] <= merged;
  end

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign done   = done_q;
  assign tohost = tohost_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: directed scenarios plus random traffic checked against a word-level memory model.
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        en1 = 1'b0;
  logic        en5 = 1'b0;

  logic [31:0] rdata_1, rdata_2, rdata_5, tohost_1, tohost_2, tohost_5;
  logic        ready_1, ready_2, ready_5, err_1, err_2, err_5, done_1, done_2, done_5;

  int total = 0;
  int bad = 0;

  logic [31:0] mdl [0:1023];
  bit          mvld [0:1023];
  logic [31:0] m_tohost = '0;
  bit          m_done = 1'b0;

  always #5 clk = ~clk;

  dmem_wait_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .write(write), .read(read), .rdata(rdata_2), .ready(ready_2), .err(err_2),
    .done(done_2), .tohost(tohost_2));

  dmem_wait_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .write(write & en1), .read(read & en1), .rdata(rdata_1), .ready(ready_1), .err(err_1),
    .done(done_1), .tohost(tohost_1));

  dmem_wait_responder #(.LATENCY(5)) u_l5 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .write(write & en5), .read(read & en5), .rdata(rdata_5), .ready(ready_5), .err(err_5),
    .done(done_5), .tohost(tohost_5));

  // Reference: byte-merge into a word array or the tohost word; unknown RAM words are tracked as invalid.
  task automatic model_exp(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] exp_rd, output bit exp_known,
                           output logic exp_err);
    logic [9:0]  idx;
    bit          th, inr;
    logic [31:0] nw;
    idx = a[11:2];
    th  = (a[31:2] == 30'h400);
    inr = (a[31:12] == 20'h0);
    exp_err   = (rd && wr) || (!th && !inr);
    exp_rd    = '0;
    exp_known = !wr;
    if (rd && !wr) begin
      if (th) exp_rd = m_tohost;
      else if (inr) begin
        exp_known = mvld[idx];
        exp_rd    = mdl[idx];
      end
    end
    if (wr) begin
      nw = th ? m_tohost : mdl[idx];
      for (int b = 0; b < 4; b++) if (s[b]) nw[b*8 +: 8] = d[b*8 +: 8];
      if (th) begin
        m_tohost = nw;
        if (nw == 32'hdeadbeef) m_done = 1'b1;
      end else if (inr) begin
        mvld[idx] = mvld[idx] || (s == 4'hf);
        mdl[idx]  = nw;
      end
    end
  endtask

  // Called just after a posedge; returns once the completing edge has passed.
  task automatic xact(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] got_rd, output logic got_err,
                      output int lat, output logic [31:0] exp_rd, output bit exp_known,
                      output logic exp_err);
    model_exp(wr, rd, a, d, s, exp_rd, exp_known, exp_err);
    addr = a; wdata = d; wstrb = s; write = wr; read = rd;
    @(posedge clk);
    lat = 0; got_rd = '0; got_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready_2) begin
        lat = k; got_rd = rdata_2; got_err = err_2;
        break;
      end
    end
    total++;
    if (lat == 0) begin
      bad++;
      $display("FAIL ready_timeout addr=%h got no ready within 20 cycles", a);
    end
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (ready_2 !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready_2); end
    total++; if (err_2 !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_2); end
    total++; if (rdata_2 !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata_2); end
    total++; if (done_2 !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done_2); end
    total++; if (tohost_2 !== 32'h0) begin bad++; $display("FAIL rst_tohost got=%h exp=0", tohost_2); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({ready_1, ready_2, ready_5} !== 3'b000) begin bad++; $display("FAIL post_rst_ready got=%b exp=000", {ready_1, ready_2, ready_5}); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_latency();
    logic [31:0] g, e; logic ge, ee; int lat; bit kn;
    xact(1'b1, 1'b0, 32'h10, 32'h1234_5678, 4'hf, g, ge, lat, e, kn, ee);
    xact(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (lat != 2) begin bad++; $display("FAIL read_latency got=%0d exp=2", lat); end
    total++; if (g !== 32'h1234_5678) begin bad++; $display("FAIL read_data got=%h exp=12345678", g); end
    total++; if (ge !== 1'b0) begin bad++; $display("FAIL read_err got=%b exp=0", ge); end
    @(negedge clk);
    total++; if (rdata_2 !== 32'h0) begin bad++; $display("FAIL rdata_idle got=%h exp=0", rdata_2); end
    @(posedge clk); #1;
  endtask

  task automatic test_masked_write();
    logic [31:0] g, e; logic ge, ee; int lat; bit kn;
    xact(1'b1, 1'b0, 32'h20, 32'h1111_1111, 4'hf, g, ge, lat, e, kn, ee);
    xact(1'b1, 1'b0, 32'h20, 32'hAABB_CCDD, 4'b0101, g, ge, lat, e, kn, ee);
    total++; if (ge !== 1'b0) begin bad++; $display("FAIL mwrite_err got=%b exp=0", ge); end
    xact(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (g !== 32'h11BB_11DD) begin bad++; $display("FAIL mwrite_readback got=%h exp=11bb11dd", g); end
  endtask

  task automatic test_back_to_back();
    int lats [3] = '{1, 2, 5};
    int last [3] = '{0, 0, 0};
    int cnt  [3] = '{0, 0, 0};
    logic [2:0] rdy;
    addr = 32'h10; read = 1'b1; en1 = 1'b1; en5 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      rdy = {ready_5, ready_2, ready_1};
      for (int j = 0; j < 3; j++) begin
        if (rdy[j]) begin
          total++;
          if (cnt[j] == 0) begin
            if (k != lats[j]) begin bad++; $display("FAIL b2b_first_L%0d got=%0d exp=%0d", lats[j], k, lats[j]); end
          end else if (k - last[j] != lats[j] + 1) begin
            bad++; $display("FAIL b2b_period_L%0d got=%0d exp=%0d", lats[j], k - last[j], lats[j] + 1);
          end
          last[j] = k;
          cnt[j]++;
        end
      end
      if (ready_2) begin
        total++;
        if (rdata_2 !== 32'h1234_5678) begin bad++; $display("FAIL b2b_rdata got=%h exp=12345678", rdata_2); end
      end
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (cnt[j] != (40 - lats[j]) / (lats[j] + 1) + 1)
        begin bad++; $display("FAIL b2b_count_L%0d got=%0d exp=%0d", lats[j], cnt[j], (40 - lats[j]) / (lats[j] + 1) + 1); end
    end
    @(posedge clk); #1;
    read = 1'b0;
    repeat (8) @(posedge clk);
    #1; en1 = 1'b0; en5 = 1'b0;
  endtask

  task automatic test_tohost();
    logic [31:0] g, e; logic ge, ee; int lat; bit kn;
    xact(1'b1, 1'b0, 32'h1000, 32'hFFFF_BEEF, 4'b0011, g, ge, lat, e, kn, ee);
    @(negedge clk);
    total++; if (tohost_2 !== 32'h0000_BEEF) begin bad++; $display("FAIL tohost_partial got=%h exp=0000beef", tohost_2); end
    total++; if (done_2 !== 1'b0) begin bad++; $display("FAIL done_early got=%b exp=0", done_2); end
    @(posedge clk); #1;
    xact(1'b1, 1'b0, 32'h1000, 32'hDEAD_0000, 4'b1100, g, ge, lat, e, kn, ee);
    total++; if (done_2 !== 1'b1) begin bad++; $display("FAIL done_set got=%b exp=1", done_2); end
    total++; if (tohost_2 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tohost_val got=%h exp=deadbeef", tohost_2); end
    xact(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (g !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tohost_read got=%h exp=deadbeef", g); end
    total++; if (ge !== 1'b0) begin bad++; $display("FAIL tohost_err got=%b exp=0", ge); end
  endtask

  task automatic test_errors();
    logic [31:0] g, e; logic ge, ee; int lat; bit kn;
    xact(1'b0, 1'b1, 32'h1004, 32'h0, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (ge !== 1'b1 || g !== 32'h0) begin bad++; $display("FAIL oor_read err=%b rdata=%h exp err=1 rdata=0", ge, g); end
    xact(1'b0, 1'b1, 32'h0010_0000, 32'h0, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (ge !== 1'b1 || g !== 32'h0) begin bad++; $display("FAIL oor_far err=%b rdata=%h exp err=1 rdata=0", ge, g); end
    xact(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (ge !== 1'b1 || g !== 32'h0) begin bad++; $display("FAIL rw_both err=%b rdata=%h exp err=1 rdata=0", ge, g); end
    xact(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (g !== 32'h11BB_11DD || ge !== 1'b0) begin bad++; $display("FAIL rw_unchanged got=%h err=%b exp=11bb11dd err=0", g, ge); end
    xact(1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 4'hf, g, ge, lat, e, kn, ee);
    xact(1'b1, 1'b0, 32'h2000, 32'h5555_5555, 4'hf, g, ge, lat, e, kn, ee);
    total++; if (ge !== 1'b1) begin bad++; $display("FAIL oor_write_err got=%b exp=1", ge); end
    xact(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (g !== 32'hCAFE_F00D) begin bad++; $display("FAIL oor_no_alias got=%h exp=cafef00d", g); end
  endtask

  task automatic test_random();
    logic [31:0] g, e, a, d; logic ge, ee, wr; int lat, pick; bit kn; logic [3:0] s;
    for (int i = 0; i < 80; i++) begin
      pick = $urandom_range(0, 19);
      if (pick == 0)      a = 32'h1000 | $urandom_range(0, 3);
      else if (pick <= 2) a = ($urandom_range(1025, 60000) << 2) | $urandom_range(0, 3);
      else                a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      xact(wr, !wr, a, d, s, g, ge, lat, e, kn, ee);
      total++; if (lat != 2) begin bad++; $display("FAIL rnd_latency i=%0d got=%0d exp=2", i, lat); end
      total++; if (ge !== ee) begin bad++; $display("FAIL rnd_err i=%0d addr=%h got=%b exp=%b", i, a, ge, ee); end
      if (kn) begin
        total++; if (g !== e) begin bad++; $display("FAIL rnd_rdata i=%0d addr=%h got=%h exp=%h", i, a, g, e); end
      end
      total++; if (tohost_2 !== m_tohost || done_2 !== m_done)
        begin bad++; $display("FAIL rnd_tohost i=%0d got=%h/%b exp=%h/%b", i, tohost_2, done_2, m_tohost, m_done); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g, e; logic ge, ee; int lat; bit kn; bit saw;
    xact(1'b1, 1'b0, 32'h40, 32'h600D_0001, 4'hf, g, ge, lat, e, kn, ee);
    addr = 32'h40; wdata = 32'hBAAD_0002; wstrb = 4'hf; write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; write = 1'b0; saw = 1'b0;
    m_tohost = '0; m_done = 1'b0;
    repeat (3) begin @(negedge clk); if (ready_2) saw = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (ready_2) saw = 1'b1; end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=1 exp=0"); end
    total++; if (done_2 !== 1'b0 || tohost_2 !== 32'h0) begin bad++; $display("FAIL rstmid_tohost got=%h/%b exp=0/0", tohost_2, done_2); end
    @(posedge clk); #1;
    xact(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, g, ge, lat, e, kn, ee);
    total++; if (g !== 32'h600D_0001) begin bad++; $display("FAIL rstmid_ram got=%h exp=600d0001", g); end
    total++; if (lat != 2) begin bad++; $display("FAIL rstmid_idle got=%0d exp=2", lat); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_masked_write();
    test_back_to_back();
    test_tohost();
    test_errors();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
